// File: rtl/cmsdk_apb4_eg_slave_bridge.sv
`default_nettype none
// ============================================================================
// Module   : cmsdk_apb4_eg_slave_bridge
// Purpose  : APB4 slave front end for the example register bank. Registers a
//            transfer, inserts ws_cfg wait states, issues a single read/write
//            strobe and returns registered prdata/pready/pslverr.
// Option   : APB4_EG_SLAVE_PROT_CHECK_EN - reject unprivileged transfers
// Revision : 1.0 - initial release
// ============================================================================
module cmsdk_apb4_eg_slave_bridge #(
   parameter int ADDRWIDTH = 12
) (
   input  logic                 pclk,
   input  logic                 presetn,
   input  logic                 psel,
   input  logic                 penable,
   input  logic                 pwrite,
   input  logic [ADDRWIDTH-1:0] paddr,
   input  logic [31:0]          pwdata,
   input  logic [3:0]           pstrb,
   input  logic [2:0]           pprot,
   output logic [31:0]          prdata,
   output logic                 pready,
   output logic                 pslverr,
   input  logic [3:0]           ws_cfg,
   output logic [ADDRWIDTH-1:0] addr,
   output logic                 read_en,
   output logic                 write_en,
   output logic [3:0]           byte_strobe,
   output logic [31:0]          wdata,
   input  logic [31:0]          rdata
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COUNT  = 2'd1,
      ST_STROBE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t       state;
   logic [3:0]   cnt;
   logic         write_q;
   logic         err_q;
   logic [2:0]   prot_q;

   logic         id_hit;
   logic         prot_fail;
   logic         setup_err;
   logic         setup;
   logic         unused_prot;

   // Top 64-byte window of the 4 KB slot holds read-only ID registers.
   assign id_hit = pwrite && (paddr[11:6] == 6'h3F);

`ifdef APB4_EG_SLAVE_PROT_CHECK_EN
   assign prot_fail = ~pprot[0];
`else
   assign prot_fail = 1'b0;
`endif

   assign setup_err   = id_hit | prot_fail;
   assign setup       = psel & ~penable;
   assign unused_prot = ^prot_q;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state       <= ST_IDLE;
         cnt         <= 4'd0;
         write_q     <= 1'b0;
         err_q       <= 1'b0;
         prot_q      <= 3'b000;
         prdata      <= 32'h0;
         pready      <= 1'b0;
         pslverr     <= 1'b0;
         addr        <= '0;
         read_en     <= 1'b0;
         write_en    <= 1'b0;
         byte_strobe <= 4'b0000;
         wdata       <= 32'h0;
      end else begin
         // Strobes are single-cycle pulses: set only on entry to STROBE.
         read_en  <= 1'b0;
         write_en <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (setup) begin
                  addr        <= paddr;
                  write_q     <= pwrite;
                  wdata       <= pwdata;
                  byte_strobe <= pwrite ? pstrb : 4'b0000;
                  prot_q      <= pprot;
                  cnt         <= ws_cfg;
                  err_q       <= setup_err;
                  if (ws_cfg != 4'd0) begin
                     state <= ST_COUNT;
                  end else begin
                     state <= ST_STROBE;
                     if (!setup_err) begin
                        write_en <= pwrite;
                        read_en  <= ~pwrite;
                     end
                  end
               end else if (psel && penable) begin
                  // Access phase without a setup phase: fail it without touching the bank.
                  err_q   <= 1'b1;
                  pready  <= 1'b1;
                  pslverr <= 1'b1;
                  prdata  <= 32'h0;
                  state   <= ST_DONE;
               end
            end

            ST_COUNT: begin
               if (!psel) begin
                  cnt   <= 4'd0;
                  state <= ST_IDLE;
               end else if (cnt == 4'd1) begin
                  cnt   <= 4'd0;
                  state <= ST_STROBE;
                  if (!err_q) begin
                     write_en <= write_q;
                     read_en  <= ~write_q;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end

            ST_STROBE: begin
               if (!psel) begin
                  state <= ST_IDLE;
               end else begin
                  // rdata is combinational from addr/read_en, valid during this cycle.
                  prdata  <= (err_q || write_q) ? 32'h0 : rdata;
                  pready  <= 1'b1;
                  pslverr <= err_q;
                  state   <= ST_DONE;
               end
            end

            ST_DONE: begin
               prdata  <= 32'h0;
               pready  <= 1'b0;
               pslverr <= 1'b0;
               state   <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cmsdk_apb4_eg_slave_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmsdk_apb4_eg_slave_bridge
// Purpose  : Directed vector bench for the APB4 example slave bridge.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cmsdk_apb4_eg_slave_bridge;

   localparam int AW = 12;
`ifdef APB4_EG_SLAVE_PROT_CHECK_EN
   localparam bit PROT_EN = 1'b1;
`else
   localparam bit PROT_EN = 1'b0;
`endif

   logic          pclk = 1'b0;
   logic          presetn;
   logic          psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [31:0]   pwdata;
   logic [3:0]    pstrb;
   logic [2:0]    pprot;
   logic [31:0]   prdata;
   logic          pready, pslverr;
   logic [3:0]    ws_cfg;
   logic [AW-1:0] addr;
   logic          read_en, write_en;
   logic [3:0]    byte_strobe;
   logic [31:0]   wdata;
   logic [31:0]   rdata;
   logic [31:0]   rd_model;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 pclk = ~pclk;

   // Register-bank model: drives the vector's read value only while read_en is high.
   assign rdata = read_en ? rd_model : 32'h5A5A_5A5A;

   cmsdk_apb4_eg_slave_bridge #(.ADDRWIDTH(AW)) dut (
      .pclk        (pclk),
      .presetn     (presetn),
      .psel        (psel),
      .penable     (penable),
      .pwrite      (pwrite),
      .paddr       (paddr),
      .pwdata      (pwdata),
      .pstrb       (pstrb),
      .pprot       (pprot),
      .prdata      (prdata),
      .pready      (pready),
      .pslverr     (pslverr),
      .ws_cfg      (ws_cfg),
      .addr        (addr),
      .read_en     (read_en),
      .write_en    (write_en),
      .byte_strobe (byte_strobe),
      .wdata       (wdata),
      .rdata       (rdata)
   );

   typedef struct {
      logic        wr;
      logic [11:0] a;
      logic [31:0] wd;
      logic [3:0]  st;
      logic [2:0]  prot;
      logic [3:0]  ws;
      logic [31:0] rd;
      logic [31:0] exp_prdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   // Runs one complete transfer starting from a cycle where the bridge is idle.
   task automatic do_xfer(input vec_t v);
      int cyc, nr, nw, scyc;
      bit got;
      psel = 1'b1; penable = 1'b0; pwrite = v.wr; paddr = v.a;
      pwdata = v.wd; pstrb = v.st; pprot = v.prot; ws_cfg = v.ws; rd_model = v.rd;
      step();
      // Disturb inputs after setup; the captured copies must not follow.
      penable = 1'b1; ws_cfg = v.ws ^ 4'hA; pwdata = ~v.wd; pstrb = ~v.st;
      cyc = 1; nr = 0; nw = 0; scyc = -1; got = 1'b0;
      while (!got && cyc <= 20) begin
         chk("strobe_exclusive", 32'(read_en & write_en), 32'h0);
         if (read_en || write_en) begin
            nr += int'(read_en);
            nw += int'(write_en);
            scyc = cyc;
            chk("addr", 32'(addr), 32'(v.a));
            chk("wdata", wdata, v.wd);
            chk("byte_strobe", 32'(byte_strobe), v.wr ? 32'(v.st) : 32'h0);
         end
         if (pready) begin
            got = 1'b1;
            chk("done_cycle", 32'(cyc), 32'(v.ws) + 32'd2);
            chk("prdata", prdata, v.exp_prdata);
            chk("pslverr", 32'(pslverr), 32'(v.exp_err));
         end else begin
            chk("prdata_not_done", prdata, 32'h0);
            step();
            cyc++;
         end
      end
      chk("pready_seen", 32'(got), 32'h1);
      chk("read_en_count", 32'(nr), 32'(!v.wr && !v.exp_err));
      chk("write_en_count", 32'(nw), 32'(v.wr && !v.exp_err));
      if (!v.exp_err) chk("strobe_cycle", 32'(scyc), 32'(v.ws) + 32'd1);
      step();
      chk("pready_drop", 32'(pready), 32'h0);
      chk("prdata_after_done", prdata, 32'h0);
      psel = 1'b0; penable = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      //            wr    addr     wdata         st     prot    ws     rdata         exp_prdata    exp_err
      vecs[0] = '{1'b1, 12'h004, 32'h12345678, 4'hF, 3'b001, 4'd0,  32'h0,        32'h0,        1'b0};
      vecs[1] = '{1'b0, 12'h004, 32'h0,        4'hF, 3'b001, 4'd3,  32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
      vecs[2] = '{1'b1, 12'hFE0, 32'hDEADBEEF, 4'hF, 3'b001, 4'd0,  32'h0,        32'h0,        1'b1};
      vecs[3] = '{1'b0, 12'hFE0, 32'h0,        4'h3, 3'b001, 4'd1,  32'h0BADF00D, 32'h0BADF00D, 1'b0};
      vecs[4] = '{1'b1, 12'h7C4, 32'hA5A5C3C3, 4'h5, 3'b011, 4'd15, 32'h0,        32'h0,        1'b0};
      vecs[5] = '{1'b0, 12'h000, 32'h0,        4'hF, 3'b000, 4'd0,  32'h11112222,
                  PROT_EN ? 32'h0 : 32'h11112222, PROT_EN};
      vecs[6] = '{1'b0, 12'h000, 32'h0,        4'hF, 3'b001, 4'd0,  32'h33334444, 32'h33334444, 1'b0};
      vecs[7] = '{1'b1, 12'hFFC, 32'h01020304, 4'hF, 3'b000, 4'd2,  32'h0,        32'h0,        1'b1};
      vecs[8] = '{1'b1, 12'hFBF, 32'h0F0F0F0F, 4'h8, 3'b001, 4'd1,  32'h0,        32'h0,        1'b0};

      presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
      pwdata = 32'h0; pstrb = 4'h0; pprot = 3'b000; ws_cfg = 4'd0; rd_model = 32'h0;
      repeat (3) step();
      chk("rst_prdata", prdata, 32'h0);
      chk("rst_pready", 32'(pready), 32'h0);
      chk("rst_pslverr", 32'(pslverr), 32'h0);
      chk("rst_addr", 32'(addr), 32'h0);
      chk("rst_strobes", 32'({read_en, write_en}), 32'h0);
      chk("rst_byte_strobe", 32'(byte_strobe), 32'h0);
      chk("rst_wdata", wdata, 32'h0);
      presetn = 1'b1;
      step();

      for (int i = 0; i < 9; i++) begin
         do_xfer(vecs[i]);
         step();
      end

      // Back-to-back: second setup lands in the cycle right after the first DONE.
      do_xfer(vecs[0]);
      do_xfer(vecs[1]);
      step();

      // Orphan access phase with no preceding setup.
      psel = 1'b1; penable = 1'b1;
      step();
      chk("orphan_pready", 32'(pready), 32'h1);
      chk("orphan_pslverr", 32'(pslverr), 32'h1);
      chk("orphan_prdata", prdata, 32'h0);
      chk("orphan_strobes", 32'({read_en, write_en}), 32'h0);
      psel = 1'b0; penable = 1'b0;
      step();
      chk("orphan_pready_drop", 32'(pready), 32'h0);

      // Abort: psel drops at T2 of a ws_cfg 5 read.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h100; ws_cfg = 4'd5;
      rd_model = 32'h77777777;
      step();
      penable = 1'b1;
      step();
      psel = 1'b0; penable = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("abort_no_strobe", 32'({read_en, write_en}), 32'h0);
         chk("abort_no_pready", 32'(pready), 32'h0);
      end
      do_xfer(vecs[6]);
      step();

      // Asynchronous reset while the write strobe is high.
      v = vecs[0];
      v.a = 12'h008;
      psel = 1'b1; penable = 1'b0; pwrite = v.wr; paddr = v.a;
      pwdata = v.wd; pstrb = v.st; pprot = v.prot; ws_cfg = 4'd0;
      step();
      penable = 1'b1;
      chk("pre_reset_write_en", 32'(write_en), 32'h1);
      #2 presetn = 1'b0;
      #1;
      chk("async_rst_write_en", 32'(write_en), 32'h0);
      chk("async_rst_addr", 32'(addr), 32'h0);
      chk("async_rst_wdata", wdata, 32'h0);
      psel = 1'b0; penable = 1'b0;
      #2 presetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_pready", 32'(pready), 32'h0);
         chk("post_rst_strobes", 32'({read_en, write_en}), 32'h0);
      end
      do_xfer(vecs[1]);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
